// File: rtl/regfile_dump.sv
// Sequential debug reader for the 32x32 register file: walks FIRST_REG..LAST_REG
// through the read port and streams each value out over a valid/ready handshake.
module regfile_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  output logic [4:0]  rdReg,
  input  logic [31:0] rdData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        hold,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_idx_q, out_idx_d;
  logic        out_last_q, out_last_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_idx_q   <= 5'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // The output word is captured in FETCH and then frozen in SEND until accepted,
  // so the consumer never sees data move under a pending valid.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        out_data_d  = rdData;
        out_idx_d   = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rdReg     = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign hold      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule
